// File: rtl/ldpc_info_pack_pkg.sv
// Shared constants and state encoding for the LDPC information-bit packer.
package ldpc_info_pack_pkg;

    localparam int unsigned LDPC_N     = 4608;
    localparam int unsigned LDPC_K_R12 = 2304;
    localparam int unsigned LDPC_K_R34 = 3456;
    localparam int unsigned CNT_W      = 13;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_INFO   = 2'd1,
        ST_PARITY = 2'd2
    } pack_state_t;

    // Index of the last systematic bit for the latched code rate.
    function automatic logic [CNT_W-1:0] k_last(input logic k_sel);
        return k_sel ? CNT_W'(LDPC_K_R34 - 1) : CNT_W'(LDPC_K_R12 - 1);
    endfunction

endpackage

// File: rtl/ldpc_byte_fifo.sv
// Small synchronous FIFO for tagged bytes; a write into a full FIFO succeeds
// only when the head is being read in the same cycle.
module ldpc_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             rd_fire;
    logic             wr_fire;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_fire = rd_en && !empty;
    assign wr_fire = wr_en && (!full || rd_fire);
    assign rd_data = mem[rd_ptr];

    // Storage is reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ldpc_info_pack.sv
// Drops parity bits from the serial decoded codeword and packs systematic
// bits MSB-first into tagged bytes buffered in a small output FIFO.
module ldpc_info_pack
    import ldpc_info_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int N_BITS     = LDPC_N
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rate,
    input  logic       sync_in,
    input  logic       din,
    input  logic       en_in,
    input  logic       blk_end,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_sop,
    output logic       out_eop,
    output logic       blk_done,
    output logic       ovf,
    output logic       len_err
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(N_BITS - 1);

    pack_state_t      state;
    pack_state_t      state_nx;
    logic [CNT_W-1:0] bit_cnt;
    logic [6:0]       sr;
    logic             k_sel;

    logic             restart;
    logic             cnt_inc;
    logic             shift_en;
    logic             fifo_wr;
    logic             done_nx;
    logic             len_set;
    logic [9:0]       fifo_wdata;
    logic [9:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_drop;

    always_comb begin
        state_nx = state;
        restart  = 1'b0;
        cnt_inc  = 1'b0;
        shift_en = 1'b0;
        fifo_wr  = 1'b0;
        done_nx  = 1'b0;
        len_set  = 1'b0;
        // sync_in restarts from any state and masks a same-cycle en_in.
        if (sync_in) begin
            state_nx = ST_INFO;
            restart  = 1'b1;
        end else if (en_in && state != ST_IDLE) begin
            if (blk_end && bit_cnt != LAST_BIT) begin
                len_set  = 1'b1;
                state_nx = ST_IDLE;
            end else if (bit_cnt == LAST_BIT) begin
                done_nx  = 1'b1;
                len_set  = !blk_end;
                state_nx = ST_IDLE;
            end else begin
                cnt_inc = 1'b1;
                if (state == ST_INFO) begin
                    shift_en = 1'b1;
                    fifo_wr  = (bit_cnt[2:0] == 3'd7);
                    if (bit_cnt == k_last(k_sel)) begin
                        state_nx = ST_PARITY;
                    end
                end
            end
        end
    end

    assign fifo_wdata = {(bit_cnt == CNT_W'(7)), (bit_cnt == k_last(k_sel)), sr, din};
    assign fifo_drop  = fifo_wr && fifo_full && !out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            sr       <= '0;
            k_sel    <= 1'b0;
            ovf      <= 1'b0;
            len_err  <= 1'b0;
            blk_done <= 1'b0;
        end else begin
            state    <= state_nx;
            blk_done <= done_nx;
            if (restart) begin
                bit_cnt <= '0;
                sr      <= '0;
                k_sel   <= rate;
                ovf     <= 1'b0;
                len_err <= 1'b0;
            end else begin
                if (cnt_inc) begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (shift_en) begin
                    sr <= {sr[5:0], din};
                end
                if (fifo_drop) begin
                    ovf <= 1'b1;
                end
                if (len_set) begin
                    len_err <= 1'b1;
                end
            end
        end
    end

    ldpc_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (10)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (out_ready),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_sop   = fifo_rdata[9];
    assign out_eop   = fifo_rdata[8];
    assign out_data  = fifo_rdata[7:0];

endmodule

// File: tb/tb_ldpc_info_pack.sv
// Directed block scenarios with random bits, checked every cycle against a
// bit-index/byte-queue model of the packer.
module tb_ldpc_info_pack;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rate, sync_in, din, en_in, blk_end, out_ready;
    logic [7:0] out_data;
    logic       out_valid, out_sop, out_eop, blk_done, ovf, len_err;

    int total = 0;
    int bad   = 0;

    // model state
    logic [9:0] q[$];
    bit         m_active;
    int         m_idx, m_k, m_pbyte;
    bit         m_ovf, m_lerr, m_done;

    // observed per-scenario tallies
    int         nxfer, nsop, neop, ndone;
    logic [7:0] last_data;

    always #5 clk = ~clk;

    ldpc_info_pack #(.FIFO_DEPTH(4), .N_BITS(4608)) dut (
        .clk(clk), .reset_n(reset_n), .rate(rate), .sync_in(sync_in), .din(din),
        .en_in(en_in), .blk_end(blk_end), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
        .blk_done(blk_done), .ovf(ovf), .len_err(len_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_active = 0; m_idx = 0; m_k = 2304; m_pbyte = 0;
        m_ovf = 0; m_lerr = 0; m_done = 0;
    endtask

    task automatic clear_tally();
        nxfer = 0; nsop = 0; neop = 0; ndone = 0; last_data = 8'h00;
    endtask

    // Called just after a falling edge: check, drive, advance model over one rising edge.
    task automatic tick(input bit s, input bit e, input bit d, input bit b, input bit r, input bit rt);
        logic [9:0] head;
        bit pop;
        chk("valid", out_valid, q.size() != 0);
        if (q.size() != 0) begin
            head = q[0];
            chk("data", out_data, head[7:0]);
            chk("sop", out_sop, head[9]);
            chk("eop", out_eop, head[8]);
        end
        chk("blk_done", blk_done, m_done);
        chk("ovf", ovf, m_ovf);
        chk("len_err", len_err, m_lerr);
        if (blk_done) ndone++;
        pop = (q.size() != 0) && r;
        if (pop) begin
            nxfer++;
            if (out_sop) nsop++;
            if (out_eop) neop++;
            last_data = out_data;
        end
        sync_in = s; en_in = e; din = d; blk_end = b; out_ready = r; rate = rt;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        m_done = 0;
        if (s) begin
            m_active = 1; m_idx = 0; m_pbyte = 0;
            m_k = rt ? 3456 : 2304;
            m_ovf = 0; m_lerr = 0;
        end else if (m_active && e) begin
            if (b && m_idx != 4607) begin
                m_lerr = 1; m_active = 0;
            end else if (m_idx == 4607) begin
                m_done = 1; m_active = 0;
                if (!b) m_lerr = 1;
            end else begin
                if (m_idx < m_k) begin
                    m_pbyte = ((m_pbyte << 1) | int'(d)) & 255;
                    if (m_idx % 8 == 7) begin
                        if (q.size() < 4) q.push_back({(m_idx == 7), (m_idx == m_k - 1), 8'(m_pbyte)});
                        else m_ovf = 1;
                    end
                end
                m_idx++;
            end
        end
        @(negedge clk);
    endtask

    // mode 0: random bits, mode 1: repeated 0xA5. out_ready low for bit indices [rlo, rhi).
    task automatic run_bits(input int nbits, input int be_at, input bit rt, input int mode,
                            input int rlo, input int rhi, input bit drain);
        byte unsigned pat = 8'hA5;
        bit d;
        tick(1, 0, 0, 0, 1, rt);
        for (int i = 0; i < nbits; i++) begin
            d = (mode == 0) ? 1'($urandom_range(1)) : pat[7 - (i % 8)];
            tick(0, 1, d, (i == be_at), !(i >= rlo && i < rhi), 1'($urandom_range(1)));
        end
        if (drain) begin
            for (int j = 0; j < 12; j++) begin
                tick(0, 1, 1'($urandom_range(1)), 1'($urandom_range(1)), 1, rt);
            end
        end
    endtask

    initial begin
        reset_n = 0; rate = 0; sync_in = 0; din = 0; en_in = 0; blk_end = 0; out_ready = 1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_sop", out_sop, 0);
        chk("rst_eop", out_eop, 0);
        chk("rst_done", blk_done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_len_err", len_err, 0);
        reset_n = 1;
        @(negedge clk);

        // rate 1/2, random bits, no backpressure
        clear_tally();
        run_bits(4608, 4607, 0, 0, 0, 0, 1);
        chk("r12_bytes", nxfer, 288);
        chk("r12_sop", nsop, 1);
        chk("r12_eop", neop, 1);
        chk("r12_done", ndone, 1);
        chk("r12_ovf", ovf, 0);
        chk("r12_len_err", len_err, 0);

        // rate 3/4, 0xA5 pattern, rate input wiggling mid-block
        clear_tally();
        run_bits(4608, 4607, 1, 1, 0, 0, 1);
        chk("r34_bytes", nxfer, 432);
        chk("r34_eop", neop, 1);
        chk("r34_last", last_data, 8'hA5);
        chk("r34_done", ndone, 1);

        // 40 cycles of backpressure: fifth byte dropped
        clear_tally();
        run_bits(4608, 4607, 0, 0, 100, 140, 1);
        chk("ovf_bytes", nxfer, 287);
        chk("ovf_sticky", ovf, 1);

        // full FIFO accepted in the same cycle as the 8th bit
        clear_tally();
        run_bits(4608, 4607, 0, 0, 0, 39, 1);
        chk("full_rd_bytes", nxfer, 288);
        chk("full_rd_ovf", ovf, 0);

        // abort after 1004 bits, then a clean block
        clear_tally();
        run_bits(1004, -1, 0, 0, 0, 0, 0);
        run_bits(4608, 4607, 0, 0, 0, 0, 1);
        chk("abort_bytes", nxfer, 125 + 288);
        chk("abort_sop", nsop, 2);
        chk("abort_eop", neop, 1);
        chk("abort_done", ndone, 1);

        // early blk_end
        clear_tally();
        run_bits(4001, 4000, 0, 0, 0, 0, 1);
        chk("early_end_bytes", nxfer, 288);
        chk("early_end_done", ndone, 0);
        chk("early_end_len_err", len_err, 1);

        // missing blk_end
        clear_tally();
        run_bits(4608, -1, 0, 0, 0, 0, 1);
        chk("no_end_done", ndone, 1);
        chk("no_end_len_err", len_err, 1);

        // async reset mid-block with a full FIFO and ovf set
        run_bits(500, -1, 1, 0, 0, 500, 0);
        chk("pre_rst_ovf", ovf, 1);
        #2 reset_n = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_data", out_data, 0);
        chk("arst_sop", out_sop, 0);
        chk("arst_eop", out_eop, 0);
        chk("arst_done", blk_done, 0);
        chk("arst_ovf", ovf, 0);
        chk("arst_len_err", len_err, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);

        clear_tally();
        run_bits(4608, 4607, 0, 0, 0, 0, 1);
        chk("post_rst_bytes", nxfer, 288);
        chk("post_rst_done", ndone, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
